// File: rtl/rf_pkg.sv
// Shared types and sizing for the architectural register file.
// Combinational helpers only; no state lives here.
// No flow control; consumers size their ports from these constants.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_word.sv
// One register-file word built from per-bit flop cells with write enable.
// Latency: q updates on the rising edge after wen/rst are sampled.
// No backpressure; reset dominates the write enable.
module rf_word
    import rf_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic q_bit;

        // Each bit is an independent enabled flop; no clock gating.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_bit <= 1'b0;
            end else if (wen) begin
                q_bit <= d[i];
            end
        end

        assign q[i] = q_bit;
    end

endmodule

// File: rtl/reg_file_bypass.sv
// Architectural register file: 2 combinational read ports, 1 clocked write port.
// Latency: reads are zero-cycle; a same-cycle write is bypassed to matching reads.
// No backpressure; writes always commit, reset wins over a concurrent write.
module reg_file_bypass
    import rf_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] src_reg1,
    input  logic [AW-1:0] src_reg2,
    input  logic [AW-1:0] dst_reg,
    input  logic          write_reg,
    input  logic [DW-1:0] dst_data,
    output logic [DW-1:0] src_data1,
    output logic [DW-1:0] src_data2
);

    localparam int NR = 2 ** AW;

    logic [NR-1:0] wen_vec;
    logic [DW-1:0] regs [NR];
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          byp1;
    logic          byp2;

    // One-hot write decoder; all zero when the write port is idle.
    always_comb begin
        wen_vec = '0;
        if (write_reg) begin
            wen_vec[dst_reg] = 1'b1;
        end
    end

    for (genvar r = 0; r < NR; r++) begin : g_reg
        rf_word #(
            .W (DW)
        ) u_word (
            .clk (clk),
            .rst (rst),
            .wen (wen_vec[r]),
            .d   (dst_data),
            .q   (regs[r])
        );
    end

    assign rd1 = regs[src_reg1];
    assign rd2 = regs[src_reg2];

    // Bypass is not qualified by rst: during reset reads still see stored data plus bypass.
    assign byp1 = write_reg && (dst_reg == src_reg1);
    assign byp2 = write_reg && (dst_reg == src_reg2);

    assign src_data1 = byp1 ? dst_data : rd1;
    assign src_data2 = byp2 ? dst_data : rd2;

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed plus randomized bench for reg_file_bypass against an array-based reference.
module tb_reg_file_bypass;

    logic        clk;
    logic        rst;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [3:0]  dst_reg;
    logic        write_reg;
    logic [15:0] dst_data;
    logic [15:0] src_data1;
    logic [15:0] src_data2;

    logic [15:0] model [16];
    int          checks;
    int          failures;

    reg_file_bypass dut (
        .clk       (clk),
        .rst       (rst),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (src_data1),
        .src_data2 (src_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] expect_rd(input logic [3:0] src);
        if (write_reg && dst_reg == src) return dst_data;
        return model[src];
    endfunction

    // Drive one cycle: optionally check reads before the edge, then commit to the model.
    task automatic cycle(input logic r, input logic we, input logic [3:0] d,
                         input logic [15:0] dat, input logic [3:0] s1,
                         input logic [3:0] s2, input bit do_chk, input string tag);
        rst       = r;
        write_reg = we;
        dst_reg   = d;
        dst_data  = dat;
        src_reg1  = s1;
        src_reg2  = s2;
        #1;
        if (do_chk) begin
            chk({tag, "_p1"}, src_data1, expect_rd(s1));
            chk({tag, "_p2"}, src_data2, expect_rd(s2));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        end else if (we) begin
            model[d] = dat;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        rst = 1'b1; write_reg = 1'b0; dst_reg = '0; dst_data = '0;
        src_reg1 = '0; src_reg2 = '0;
        @(negedge clk);

        // Reset for one edge; stored contents are unknown beforehand.
        cycle(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, "rst");
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b0, 4'd0, 16'h0, 4'(k), 4'(15 - k), 1'b0, "rd0");
            chk("reset_p1", src_data1, 16'h0000);
            chk("reset_p2", src_data2, 16'h0000);
        end

        // Write R3 then read R3/R4.
        cycle(1'b0, 1'b1, 4'd3, 16'hBEEF, 4'd0, 4'd1, 1'b1, "wr3");
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd4, 1'b0, "rd3");
        chk("wb_r3", src_data1, 16'hBEEF);
        chk("wb_r4", src_data2, 16'h0000);

        // Bypass on both ports at once.
        cycle(1'b0, 1'b1, 4'd5, 16'h1111, 4'd0, 4'd0, 1'b1, "wr5");
        write_reg = 1'b1; dst_reg = 4'd5; dst_data = 16'h2222;
        src_reg1 = 4'd5; src_reg2 = 4'd5;
        #1;
        chk("byp_p1", src_data1, 16'h2222);
        chk("byp_p2", src_data2, 16'h2222);
        @(posedge clk); model[5] = 16'h2222; #1;
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0, "rd5");
        chk("byp_after_p1", src_data1, 16'h2222);
        chk("byp_after_p2", src_data2, 16'h2222);

        // Disabled write: no bypass, no commit.
        write_reg = 1'b0; dst_reg = 4'd7; dst_data = 16'hFFFF;
        src_reg1 = 4'd7; src_reg2 = 4'd3;
        #1;
        chk("nowr_before", src_data1, 16'h0000);
        @(posedge clk); #1;
        chk("nowr_after", src_data1, 16'h0000);

        // Reset wins over a write on the same edge.
        cycle(1'b0, 1'b1, 4'd9, 16'hA5A5, 4'd9, 4'd3, 1'b1, "wr9");
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd3, 1'b0, "rd9");
        chk("r9_written", src_data1, 16'hA5A5);
        cycle(1'b1, 1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd3, 1'b1, "rstwr");
        cycle(1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd3, 1'b0, "rd9b");
        chk("rst_vs_wr", src_data1, 16'h0000);
        chk("rst_clears_r3", src_data2, 16'h0000);

        // Full sweep then paired readback.
        for (int k = 0; k < 16; k++)
            cycle(1'b0, 1'b1, 4'(k), 16'h0100 + 16'(k), 4'(k), 4'(15 - k), 1'b1, "sweep_wr");
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b0, 4'(15 - k), 16'hDEAD, 4'(k), 4'(15 - k), 1'b0, "sweep_rd");
            chk("sweep_p1", src_data1, 16'h0100 + 16'(k));
            chk("sweep_p2", src_data2, 16'h010F - 16'(k));
        end

        // Randomized traffic with occasional reset and forced index collisions.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] d, s1, s2;
            d  = 4'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            s2 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), d,
                  16'($urandom), s1, s2, 1'b1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Architectural register file for the pipelined processor, built from per-bit synchronous-reset D-flipflop cells with write enable.
- Sits between the decode stage and the writeback stage.
- Provides two combinational read ports and one clocked write port.
- Includes write-to-read bypass, so an instruction in decode sees a value written back in the same cycle.

Parameters:
- DATA_W, 16, width of each register and of all data ports
- ADDR_W, 4, register index width; register count NREGS = 2**ADDR_W (16)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
- src_reg1  input  ADDR_W  read port 1 register index
- src_reg2  input  ADDR_W  read port 2 register index
- dst_reg  input  ADDR_W  write port register index
- write_reg  input  1  write enable for write port
- dst_data  input  DATA_W  write data
- src_data1  output  DATA_W  read port 1 data
- src_data2  output  DATA_W  read port 2 data

Behaviour:
- Clocking and reset:
  - Clock is clk. Reset is rst, synchronous and active-high; no asynchronous path.
  - On a rising edge with rst=1, all NREGS registers load 0, regardless of write_reg.
- Write:
  - On a rising edge with rst=0 and write_reg=1, register[dst_reg] loads dst_data. All other registers hold.
  - With write_reg=0, every register holds.
  - Each register bit is a flop with write enable = (write_reg && decode(dst_reg)). No clock gating.
- Read, combinational with zero-cycle latency:
  - src_dataN = register[src_regN], except for the bypass case below.
- Bypass:
  - If write_reg=1 and dst_reg==src_regN, then src_dataN = dst_data in the same cycle, before the edge commits it.
  - Each port bypasses independently; both ports may bypass at once.
- Register 0 is an ordinary writable register. No hardwired zero.
- Reset interaction:
  - While rst=1, the read outputs still reflect stored contents plus bypass, i.e. they are not forced.
  - After the reset edge, all reads return 0 until written.
- Simultaneous events:
  - Read and write to the same index in one cycle: the bypassed new value is returned.
  - Write and reset on the same edge: reset wins; the register is 0.
- Out of scope: no X-propagation handling. All indices are in range by width.
- Simulation timing: flop state updates carry a 0.1 ns delay after the edge. Benches sample outputs at least 1 ns after the edge.

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W and ADDR_W constants
  - typedef reg_idx_t (logic [ADDR_W-1:0])
  - typedef word_t (logic [DATA_W-1:0])
- One natural sub-module, rf_word: a DATA_W-wide register of the existing per-bit flop cells.
  - Ports: clk, rst, wen, d, q.
  - Instantiated NREGS times via generate.
- The top level contains:
  - the write-index decoder
  - two NREGS:1 read multiplexers
  - the two bypass comparators and muxes

Test Plan:
- Reset: assert rst for 1 edge, then read indices 0..15 on both ports -> all return 16'h0000.
- Write/readback: write R3=16'hBEEF; next cycle src_reg1=3, src_reg2=4 -> src_data1=16'hBEEF, src_data2=16'h0000.
- Bypass both ports: R5 holds 16'h1111. In one cycle drive write_reg=1, dst_reg=5, dst_data=16'h2222, src_reg1=src_reg2=5 -> both outputs 16'h2222 in that cycle; 16'h2222 after the edge.
- Write disabled: write_reg=0, dst_reg=7, dst_data=16'hFFFF, src_reg1=7 -> src_data1 unchanged (0) before and after the edge; no bypass.
- Reset vs write: write R9=16'hA5A5. Then on one edge drive rst=1, write_reg=1, dst_reg=9, dst_data=16'h5A5A -> R9 reads 16'h0000 after the edge.
- Full sweep: write Rk=16'h0100+k for k=0..15 on consecutive cycles, then read pairs (k, 15-k) -> src_data1=16'h0100+k, src_data2=16'h010F-k; no cross-register corruption.
